exec_sequencer: RTL
===================

# exec_sequencer

Parametrised instruction-execution sequencer that gates program-counter advance and register-file load source around multi-cycle memory/stack accesses. It sits between the instruction decoder (which reports whether the current instruction reads and/or writes memory) and the program counter / register write-back. It generalises the fixed single-wait-cycle run/stop controller with configurable read and write wait states, a `mem_ready` handshake, a single-step mode and a retired-instruction counter.

## Interface
Parameters:
- `INSTR_W`, 16: instruction width.
- `READ_WAIT`, 1: minimum cycles spent in READ, ≥1.
- `WRITE_WAIT`, 1: minimum cycles spent in WRITE, ≥1.
- `HALT_OPCODE`, 16'h0300: instruction value that stops execution after it retires.
- `RETIRE_W`, 16: retired-instruction counter width.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `user_clock`  in  1  start/step button level, already synchronised.
- `step_mode`  in  1  1 = stop after every retired instruction; 0 = free run.
- `stop_request`  in  1  external stop (clock lock / switch clock).
- `instr`  in  INSTR_W  current instruction.
- `needs_read`  in  1  decoder: instruction loads from mem/stk.
- `needs_write`  in  1  decoder: instruction stores to mem/stk.
- `load_src_in`  in  2  decoder load source (self/alu/mem/stk).
- `mem_ready`  in  1  memory handshake; access completes when high.
- `pc_increment`  out  1  one-cycle pulse per retired instruction.
- `load_src_out`  out  2  gated load source; 2'b00 (self) except on the retire cycle.
- `mem_read_req`  out  1  high throughout READ.
- `mem_write_req`  out  1  high throughout WRITE.
- `running`  out  1  high in RUN, READ, WRITE.
- `retire_count`  out  RETIRE_W  number of retired instructions, wrapping.

## Operation
- States: STOPPED, ARMED, RUN, READ, WRITE.
- `halt = stop_request | step_mode | (instr == HALT_OPCODE)`.
- STOPPED: `user_clock`=0 → ARMED; else stay.
- ARMED: `user_clock`=1 → RUN; else stay. A press therefore requires a full release-press cycle.
- RUN: `needs_read` → READ, wait counter loaded with READ_WAIT-1; else `needs_write` → WRITE, counter loaded with WRITE_WAIT-1; else retire this cycle, then `halt` → STOPPED, else RUN.
- READ: `mem_read_req`=1; counter decrements to 0 and holds. Completes when counter==0 and `mem_ready`. On completion: `needs_write` → WRITE (counter loaded with WRITE_WAIT-1, no retire); else retire, then `halt` → STOPPED, else RUN.
- WRITE: `mem_write_req`=1; same completion rule. On completion: retire, then `halt` → STOPPED, else RUN.
- Retire cycle: `pc_increment`=1, `load_src_out`=`load_src_in`, `retire_count`+1 on that edge, wrapping modulo 2^RETIRE_W.
- `stop_request` never aborts an access in flight; it is sampled only on the retire cycle.
- Outputs are decoded combinationally from state, counter and inputs. `retire_count` is registered.

## Timing
- Reset (asynchronous, immediate): state STOPPED, counter 0, `retire_count` 0. All outputs 0, including while `reset` is held.
- Reset mid-access drops `mem_read_req`/`mem_write_req` combinationally; no retire occurs.
- No-access instruction: retires in the RUN cycle, so throughput is 1 per cycle while free-running.
- Read with READ_WAIT=N and `mem_ready` tied high: N cycles in READ, retire in the Nth cycle.
- Read+write instruction: READ_WAIT + WRITE_WAIT cycles minimum, with exactly one retire.
- `mem_ready` low stretches the state indefinitely, with no timeout.
- Wait counter width: `$clog2(max(READ_WAIT,WRITE_WAIT)+1)`.

## Structure
- Package `exec_seq_pkg` holds:
  - state enum (STOPPED=0, ARMED=1, RUN=2, READ=3, WRITE=4, 3 bits);
  - load-source constants LS_SELF=2'b00, LS_ALU=2'b01, LS_MEM=2'b10, LS_STK=2'b11;
  - default HALT_OPCODE.
- Sub-module `wait_counter`: a loadable down-counter with a `zero` flag, parametrised by width. It is instantiated once and reloaded per access phase.

## Test plan
- Reset asserted in READ with READ_WAIT=3 → `mem_read_req` falls without a clock edge. After release: STOPPED, `retire_count`=0, all outputs 0.
- `user_clock` 1→0→1, `step_mode`=0, `needs_read`=`needs_write`=0 for 5 cycles → `pc_increment` high 5 consecutive cycles, `retire_count`=5.
- READ_WAIT=3, `needs_read`=1, `load_src_in`=2'b10, `mem_ready` low 2 extra cycles → 5 cycles in READ, single `pc_increment`, `load_src_out`=2'b10 only on that cycle.
- `needs_read`=`needs_write`=1, READ_WAIT=2, WRITE_WAIT=2 → READ 2 cycles, WRITE 2 cycles, one retire, `load_src_out`=00 during READ.
- `step_mode`=1 → exactly one retire per button release-press, then STOPPED. `instr`=16'h0300 in free run → retires then STOPPED.
- `stop_request` pulsed mid-WRITE → WRITE completes, retire, then STOPPED. With RETIRE_W=4, 17 retires → `retire_count`=1.

Source files
------------

// File: rtl/exec_seq_pkg.sv
// Shared types and constants for the execution sequencer: FSM state encoding,
// register-file load-source codes and the default halt instruction.
package exec_seq_pkg;

    typedef enum logic [2:0] {
        STOPPED = 3'd0,
        ARMED   = 3'd1,
        RUN     = 3'd2,
        READ    = 3'd3,
        WRITE   = 3'd4
    } state_t;

    localparam logic [1:0] LS_SELF = 2'b00;
    localparam logic [1:0] LS_ALU  = 2'b01;
    localparam logic [1:0] LS_MEM  = 2'b10;
    localparam logic [1:0] LS_STK  = 2'b11;

    localparam logic [15:0] DEFAULT_HALT_OPCODE = 16'h0300;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/exec_sequencer_wait_counter.sv
// Loadable down-counter that stops at zero; paces the minimum length of each
// memory access phase.
module wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;
    logic             w_zero;

    assign w_zero = (r_count == '0);
    assign o_zero = w_zero;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (!w_zero) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/exec_sequencer.sv
// Run/stop sequencer: gates PC advance and write-back source around
// multi-cycle memory reads/writes, with single-step and a retire counter.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int                 INSTR_W     = 16,
    parameter int                 READ_WAIT   = 1,
    parameter int                 WRITE_WAIT  = 1,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = INSTR_W'(DEFAULT_HALT_OPCODE),
    parameter int                 RETIRE_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                user_clock,
    input  logic                step_mode,
    input  logic                stop_request,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                needs_read,
    input  logic                needs_write,
    input  logic [1:0]          load_src_in,
    input  logic                mem_ready,
    output logic                pc_increment,
    output logic [1:0]          load_src_out,
    output logic                mem_read_req,
    output logic                mem_write_req,
    output logic                running,
    output logic [RETIRE_W-1:0] retire_count
);

    localparam int CNT_W = $clog2(max_int(READ_WAIT, WRITE_WAIT) + 1);
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_WAIT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [RETIRE_W-1:0] r_retire_count;
    logic                w_halt;
    logic                w_done;
    logic                w_retire;
    logic                w_cnt_load;
    logic [CNT_W-1:0]    w_cnt_value;
    logic                w_cnt_zero;
    logic                w_read_req;
    logic                w_write_req;

    wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_cnt_load),
        .i_value (w_cnt_value),
        .o_zero  (w_cnt_zero)
    );

    assign w_halt = stop_request | step_mode | (instr == HALT_OPCODE);
    assign w_done = w_cnt_zero & mem_ready;

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_value  = READ_LOAD;
        w_read_req   = 1'b0;
        w_write_req  = 1'b0;
        case (r_state)
            STOPPED: if (!user_clock) w_state_next = ARMED;
            ARMED:   if (user_clock)  w_state_next = RUN;
            RUN: begin
                if (needs_read) begin
                    w_cnt_load   = 1'b1;
                    w_state_next = READ;
                end else if (needs_write) begin
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = WRITE_LOAD;
                    w_state_next = WRITE;
                end else begin
                    w_retire = 1'b1;
                end
            end
            READ: begin
                w_read_req = 1'b1;
                if (w_done) begin
                    if (needs_write) begin
                        w_cnt_load   = 1'b1;
                        w_cnt_value  = WRITE_LOAD;
                        w_state_next = WRITE;
                    end else begin
                        w_retire = 1'b1;
                    end
                end
            end
            WRITE: begin
                w_write_req = 1'b1;
                if (w_done) w_retire = 1'b1;
            end
            default: w_state_next = STOPPED;
        endcase
        // Halt sources are only honoured once the instruction has retired.
        if (w_retire) w_state_next = w_halt ? STOPPED : RUN;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= STOPPED;
            r_retire_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_retire) r_retire_count <= r_retire_count + 1'b1;
        end
    end

    assign pc_increment  = w_retire;
    assign load_src_out  = w_retire ? load_src_in : LS_SELF;
    assign mem_read_req  = w_read_req;
    assign mem_write_req = w_write_req;
    assign running       = (r_state == RUN) || (r_state == READ) || (r_state == WRITE);
    assign retire_count  = r_retire_count;

endmodule
